// File: rtl/store_unload_ctrl.sv
// store_unload_ctrl
// Drain side of the load/store volume counter. While the store is empty it
// requests a refill from the loader. A full indication loads N units into the
// store, which are then handed to a sink one unit per valid/ready handshake.
// Spurious full indications and prolonged sink stalls raise a sticky error.
module store_unload_ctrl #(
  parameter int N     = 750,
  parameter int CBITS = 10,
  parameter int TMO   = 1023,
  parameter int TBITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_full_in,
  output logic             o_load_req,
  output logic             o_unit_valid,
  input  logic             i_unit_ready,
  output logic [CBITS-1:0] o_level,
  output logic             o_empty,
  output logic             o_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [CBITS-1:0] LVL_FULL  = CBITS'(N);
  localparam logic [CBITS-1:0] LVL_ONE   = CBITS'(1);
  localparam logic [CBITS-1:0] LVL_ZERO  = CBITS'(0);
  localparam logic [TBITS-1:0] STALL_MAX = TBITS'(TMO);
  localparam logic [TBITS-1:0] STALL_ONE = TBITS'(1);
  localparam logic [TBITS-1:0] STALL_CLR = TBITS'(0);

  state_t           r_state;
  state_t           w_state_next;
  logic [CBITS-1:0] r_level;
  logic [CBITS-1:0] w_level_next;
  logic [TBITS-1:0] r_stall;
  logic [TBITS-1:0] w_stall_next;
  logic [TBITS-1:0] w_stall_inc;
  logic             r_err;
  logic             w_err_next;

  // Saturating stall count: holds at STALL_MAX once reached.
  always_comb begin
    w_stall_inc = r_stall;
    if (r_stall == STALL_MAX) begin
      w_stall_inc = r_stall;
    end else begin
      w_stall_inc = r_stall + STALL_ONE;
    end
  end

  // Next-state, level, stall watchdog and sticky error decode.
  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_stall_next = STALL_CLR;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        // full_in is only honoured here, so a refill needs at least one IDLE cycle.
        if (i_full_in) begin
          w_state_next = ST_DRAIN;
          w_level_next = LVL_FULL;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_unit_ready) begin
          // DRAIN always holds level >= 1, so this never wraps.
          w_level_next = r_level - LVL_ONE;
          w_stall_next = STALL_CLR;
          if (r_level == LVL_ONE) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DRAIN;
          end
        end else begin
          w_stall_next = w_stall_inc;
          if (w_stall_inc == STALL_MAX) begin
            w_err_next = 1'b1;
          end else begin
            w_err_next = r_err;
          end
        end
        // The loader may keep full asserted while the store is still untouched.
        if (i_full_in && (r_level != LVL_FULL)) begin
          w_err_next = 1'b1;
        end else begin
          w_err_next = w_err_next;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_level_next = LVL_ZERO;
      end
    endcase
  end

  // State registers with synchronous reset that overrides all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_level <= LVL_ZERO;
      r_stall <= STALL_CLR;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_level <= w_level_next;
      r_stall <= w_stall_next;
      r_err   <= w_err_next;
    end
  end

  assign o_load_req   = (r_state == ST_IDLE);
  assign o_unit_valid = (r_state == ST_DRAIN);
  assign o_level      = r_level;
  assign o_empty      = (r_level == LVL_ZERO);
  assign o_err        = r_err;

endmodule

// File: tb/tb_store_unload_ctrl.sv
// Directed bench for store_unload_ctrl with a scoreboard of per-unit levels.
module tb_store_unload_ctrl;

  localparam int N     = 750;
  localparam int CBITS = 10;
  localparam int TMO   = 16;
  localparam int TBITS = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             full_in;
  logic             unit_ready;
  logic             load_req;
  logic             unit_valid;
  logic [CBITS-1:0] level;
  logic             empty;
  logic             err;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int exp_q[$];

  store_unload_ctrl #(.N(N), .CBITS(CBITS), .TMO(TMO), .TBITS(TBITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_full_in    (full_in),
    .o_load_req   (load_req),
    .o_unit_valid (unit_valid),
    .i_unit_ready (unit_ready),
    .o_level      (level),
    .o_empty      (empty),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard any handshake that will complete on this edge, then
  // advance and settle 1 time unit past the edge.
  task automatic step();
    int e;
    if (unit_valid && unit_ready && !rst) begin
      xfers++;
      check("xfer_queue_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("xfer_level", int'(level), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fill();
    for (int v = N; v >= 1; v--) exp_q.push_back(v);
  endtask

  task automatic drain_to_idle(input int budget);
    int n;
    n = 0;
    unit_ready = 1'b1;
    while (unit_valid && n < budget) begin
      step();
      n++;
    end
    check("drain_done", int'(unit_valid), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_load_req"}, int'(load_req), 1);
    check({tag, "_valid"}, int'(unit_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int nonmono;
    rst = 1'b1; full_in = 1'b0; unit_ready = 1'b0;
    #1;
    // 1. reset
    step(); step();
    check_idle("reset");
    check("reset_err", int'(err), 0);
    rst = 1'b0;

    // 2. full pulse, sink always ready
    full_in = 1'b1;
    step();
    full_in = 1'b0;
    expect_fill();
    check("t2_level", int'(level), N);
    check("t2_valid", int'(unit_valid), 1);
    check("t2_load_req", int'(load_req), 0);
    check("t2_empty", int'(empty), 0);
    xfers = 0;
    drain_to_idle(N + 10);
    check("t2_xfers", xfers, N);
    check("t2_queue_left", exp_q.size(), 0);
    check_idle("t2_end");
    check("t2_err", int'(err), 0);

    // 3. ready toggling every cycle
    full_in = 1'b1;
    step();
    full_in = 1'b0;
    expect_fill();
    xfers = 0; nonmono = 0; prev = int'(level);
    for (int i = 0; i < 2 * N; i++) begin
      unit_ready = (i % 2 == 0);
      step();
      if (int'(level) > prev) nonmono = 1;
      prev = int'(level);
    end
    check("t3_xfers", xfers, N);
    check("t3_monotonic", nonmono, 0);
    check_idle("t3_end");
    check("t3_err", int'(err), 0);

    // 4. full held at level N is legal; full at level N-1 is an error
    unit_ready = 1'b0; full_in = 1'b1;
    step();
    expect_fill();
    xfers = 0;
    step(); step(); step();
    check("t4_hold_level", int'(level), N);
    check("t4_hold_err", int'(err), 0);
    full_in = 1'b0; unit_ready = 1'b1;
    step();
    check("t4_level_after_first", int'(level), N - 1);
    check("t4_err_before_pulse", int'(err), 0);
    full_in = 1'b1;
    step();
    full_in = 1'b0;
    check("t4_err_after_pulse", int'(err), 1);
    check("t4_level_after_pulse", int'(level), N - 2);
    drain_to_idle(N + 10);
    check("t4_xfers", xfers, N);
    check("t4_err_sticky", int'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_err_cleared", int'(err), 0);

    // 5. stall watchdog with TMO=16
    full_in = 1'b1; unit_ready = 1'b0;
    step();
    full_in = 1'b0;
    expect_fill();
    xfers = 0;
    for (int i = 0; i < TMO - 1; i++) step();
    check("t5_stall15_level", int'(level), N);
    check("t5_stall15_err", int'(err), 0);
    unit_ready = 1'b1;
    step();
    check("t5_after_xfer_err", int'(err), 0);
    check("t5_after_xfer_level", int'(level), N - 1);
    unit_ready = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    check("t5_stall15b_err", int'(err), 0);
    step();
    check("t5_stall16_err", int'(err), 1);
    check("t5_stall16_level", int'(level), N - 1);
    drain_to_idle(N + 10);
    check("t5_xfers", xfers, N);
    check("t5_err_sticky", int'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 6. reset mid-drain with full_in asserted
    full_in = 1'b1;
    step();
    full_in = 1'b0;
    expect_fill();
    xfers = 0; unit_ready = 1'b1;
    for (int i = 0; i < N - 300; i++) step();
    check("t6_level_300", int'(level), 300);
    rst = 1'b1; full_in = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_idle("t6_rst");
    check("t6_rst_err", int'(err), 0);
    check("t6_xfers_before", xfers, N - 300);
    step();
    full_in = 1'b0;
    expect_fill();
    check("t6_recapture_level", int'(level), N);
    check("t6_recapture_valid", int'(unit_valid), 1);
    xfers = 0;
    drain_to_idle(N + 10);
    check("t6_xfers", xfers, N);
    check_idle("t6_end");
    check("t6_err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
